div_share_arbiter: RTL
======================

Name: div_share_arbiter

Overview:
Shares one sequential signed divider (N-bit, truncating quotient, remainder takes dividend sign) between two requesters. Round-robin arbitration latches the winner's operands, pulses the divider start, waits for valid/error with a watchdog, and returns the result tagged to the winner. It sits between client datapaths and the divider instance.

Parameters:
N, 5, operand/result width (signed two's complement)
TIMEOUT, 64, max WAIT cycles before watchdog abort (>=2)

Ports:
clk  in  1  rising-edge clock
rst  in  1  synchronous, active-high reset
req  in  2  req[i]: requester i has operands ready; held until ack[i]
a0, b0  in  N  requester 0 dividend/divisor, stable while req[0]
a1, b1  in  N  requester 1 dividend/divisor, stable while req[1]
ack  out  2  one-cycle pulse: request accepted, operands captured
done  out  2  one-cycle pulse: result for requester i on q/r/err
q  out  N  signed quotient, valid while done!=0
r  out  N  signed remainder, valid while done!=0
err  out  1  divide-by-zero or timeout, valid while done!=0
timeout  out  1  watchdog abort flag, valid while done!=0
busy  out  1  high in ISSUE and WAIT
div_a, div_b  out  N  operands to divider, held from ISSUE through WAIT
div_start  out  1  one-cycle start pulse to divider
div_busy  in  1  divider busy
div_valid  in  1  divider result valid
div_error  in  1  divider divide-by-zero
div_q, div_r  in  N  divider quotient/remainder

Behaviour:
- All outputs registered. Reset: state=IDLE, ack=0, done=0, q=r=0, err=0, timeout=0, div_start=0, div_a=div_b=0, busy=0, priority pointer=0 (requester 0 favoured), watchdog=0. Reset mid-operation abandons the transaction with no done pulse; clients re-request.
- States: IDLE, ISSUE, WAIT.
- IDLE: if req!=0 and div_busy==0: pick winner (only requester, or pointer's favourite if both); capture operands into div_a/div_b; ack[winner]<=1; pointer<=other requester; ->ISSUE. Else stay. req ignored while div_busy=1.
- ISSUE (1 cycle): ack<=0; div_start<=1; watchdog<=0; ->WAIT.
- WAIT: div_start<=0. div_valid/div_error ignored in the cycle div_start is high; sampled from the next cycle.
  - div_error=1 (takes precedence over div_valid): q<=0, r<=0, err<=1, timeout<=0, done[winner]<=1, ->IDLE.
  - div_valid=1: q<=div_q, r<=div_r, err<=0, timeout<=0, done[winner]<=1, ->IDLE.
  - neither, watchdog==TIMEOUT-1: q<=0, r<=0, err<=1, timeout<=1, done[winner]<=1, ->IDLE; else watchdog++.
- done, err, timeout high one cycle; q/r hold until the next done. Arbitration may occur in the cycle done is high.
- Latency: req sampled at edge E0 -> ack high after E0; div_start high after E1; done high the cycle after div_valid is first sampled high.
- A requester re-asserting req after ack is not granted before its done (FSM serialises). req dropped before ack: no grant, no error.
- Fairness: with both req continuously high, grants alternate 0,1,0,1.
- No arithmetic in block; values pass through at N bits, no extension.

Test Plan:
- rst for 1 cycle; req[0] with a0=13, b0=2 -> ack[0] one cycle, one div_start, then done[0] with q=6, r=1, err=0; busy low after.
- req[1] only: a1=10, b1=-3 -> done[1], q=-3, r=1; then a1=-7, b1=2 -> q=-3, r=-1; then a1=-14, b1=-3 -> q=4, r=-2.
- req=2'b11 held, a0=13/b0=2, a1=0/b1=2 -> ack order 0,1,0,1; done[1] gives q=0, r=0; no double grant, no starvation over 10 transactions.
- req[0] with a0=13, b0=0 -> done[0], err=1, timeout=0, q=r=0; next request completes normally.
- Stub divider never asserts div_valid, TIMEOUT=16 -> done high exactly 17 cycles after div_start (16 WAIT cycles), err=1, timeout=1; no new grant while div_busy=1.
- rst asserted during WAIT -> next cycle all outputs at reset values, no done; a fresh 13/2 request gives q=6, r=1.

Source files
------------

// File: rtl/div_share_arbiter.sv
// Round-robin front end that shares one sequential signed divider between two requesters.
// The winner's operands are held on the divider port and the result is returned tagged to it.
module div_share_arbiter #(
    parameter int unsigned N       = 5,
    parameter int unsigned TIMEOUT = 64
) (
    input  logic         clk,
    input  logic         rst,
    input  logic [1:0]   req,
    input  logic [N-1:0] a0,
    input  logic [N-1:0] b0,
    input  logic [N-1:0] a1,
    input  logic [N-1:0] b1,
    output logic [1:0]   ack,
    output logic [1:0]   done,
    output logic [N-1:0] q,
    output logic [N-1:0] r,
    output logic         err,
    output logic         timeout,
    output logic         busy,
    output logic [N-1:0] div_a,
    output logic [N-1:0] div_b,
    output logic         div_start,
    input  logic         div_busy,
    input  logic         div_valid,
    input  logic         div_error,
    input  logic [N-1:0] div_q,
    input  logic [N-1:0] div_r
);

    localparam int unsigned WdW = $clog2(TIMEOUT);
    localparam logic [WdW-1:0] WdLast = WdW'(TIMEOUT - 1);

    typedef enum logic [1:0] {
        StIdle,
        StIssue,
        StWait
    } state_e;

    state_e         state_q;
    logic [1:0]     ack_q;
    logic [1:0]     done_q;
    logic [N-1:0]   q_q;
    logic [N-1:0]   r_q;
    logic           err_q;
    logic           timeout_q;
    logic           busy_q;
    logic [N-1:0]   div_a_q;
    logic [N-1:0]   div_b_q;
    logic           div_start_q;
    logic           ptr_q;
    logic           win_q;
    logic [WdW-1:0] wd_q;

    // Pointer names the favoured requester when both are asking.
    logic win;
    assign win = (req == 2'b11) ? ptr_q : req[1];

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q     <= StIdle;
            ack_q       <= '0;
            done_q      <= '0;
            q_q         <= '0;
            r_q         <= '0;
            err_q       <= 1'b0;
            timeout_q   <= 1'b0;
            busy_q      <= 1'b0;
            div_a_q     <= '0;
            div_b_q     <= '0;
            div_start_q <= 1'b0;
            ptr_q       <= 1'b0;
            win_q       <= 1'b0;
            wd_q        <= '0;
        end else begin
            ack_q     <= '0;
            done_q    <= '0;
            err_q     <= 1'b0;
            timeout_q <= 1'b0;
            unique case (state_q)
                StIdle: begin
                    if ((req != 2'b00) && !div_busy) begin
                        win_q   <= win;
                        div_a_q <= win ? a1 : a0;
                        div_b_q <= win ? b1 : b0;
                        ack_q   <= win ? 2'b10 : 2'b01;
                        ptr_q   <= ~win;
                        busy_q  <= 1'b1;
                        state_q <= StIssue;
                    end
                end
                StIssue: begin
                    div_start_q <= 1'b1;
                    wd_q        <= '0;
                    state_q     <= StWait;
                end
                StWait: begin
                    // Divider handshakes are not trusted while the start pulse is still out.
                    if (div_start_q) begin
                        div_start_q <= 1'b0;
                    end else if (div_error) begin
                        q_q     <= '0;
                        r_q     <= '0;
                        err_q   <= 1'b1;
                        done_q  <= win_q ? 2'b10 : 2'b01;
                        busy_q  <= 1'b0;
                        state_q <= StIdle;
                    end else if (div_valid) begin
                        q_q     <= div_q;
                        r_q     <= div_r;
                        done_q  <= win_q ? 2'b10 : 2'b01;
                        busy_q  <= 1'b0;
                        state_q <= StIdle;
                    end else if (wd_q == WdLast) begin
                        q_q       <= '0;
                        r_q       <= '0;
                        err_q     <= 1'b1;
                        timeout_q <= 1'b1;
                        done_q    <= win_q ? 2'b10 : 2'b01;
                        busy_q    <= 1'b0;
                        state_q   <= StIdle;
                    end else begin
                        wd_q <= wd_q + WdW'(1);
                    end
                end
                default: state_q <= StIdle;
            endcase
        end
    end

    assign ack       = ack_q;
    assign done      = done_q;
    assign q         = q_q;
    assign r         = r_q;
    assign err       = err_q;
    assign timeout   = timeout_q;
    assign busy      = busy_q;
    assign div_a     = div_a_q;
    assign div_b     = div_b_q;
    assign div_start = div_start_q;

endmodule
